// File: rtl/iter_ctrl_if.sv
// Bundle between the Bellman-Ford top-level controller and the iteration
// controller. The controller side (master) drives state code, graph sizes
// and the relax-compare pulse; iter_ctrl (slave) returns edge index,
// pass count and pass-result flags.
//
// Handshake: relaxValid is a single-cycle pulse meaning "the compare result
// for edge edgeAddr is valid now"; relaxUpdated is only meaningful while
// relaxValid is high. iter_ctrl answers one cycle later with either goS8
// (a one-cycle pulse: next edge ready) or iterDone (a level: pass complete).
interface iter_ctrl_if #(
  parameter int EDGE_AW = 8,
  parameter int NODE_W  = 8
);
  logic [4:0]         fsm_state;
  logic [EDGE_AW-1:0] numEdges;
  logic [NODE_W-1:0]  numNodes;
  logic               relaxValid;
  logic               relaxUpdated;
  logic [EDGE_AW-1:0] edgeAddr;
  logic [NODE_W-1:0]  iterCount;
  logic               goS8;
  logic               iterDone;
  logic               iterStop;
  logic               negCycle;
  logic               updatedFlag;
  logic [1:0]         phase;

  modport master (
    output fsm_state, numEdges, numNodes, relaxValid, relaxUpdated,
    input  edgeAddr, iterCount, goS8, iterDone, iterStop, negCycle,
           updatedFlag, phase
  );

  modport slave (
    input  fsm_state, numEdges, numNodes, relaxValid, relaxUpdated,
    output edgeAddr, iterCount, goS8, iterDone, iterStop, negCycle,
           updatedFlag, phase
  );
endinterface

// File: rtl/iter_ctrl.sv
// Relaxation-pass controller: walks edgeAddr over all edges of the graph,
// accumulates whether any distance improved in the pass, counts passes and
// flags convergence or a negative cycle. All outputs come from registers.
module iter_ctrl #(
  parameter int EDGE_AW = 8,
  parameter int NODE_W  = 8
) (
  input logic         clock,
  input logic         reset,
  iter_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } phase_t;

  phase_t             phase_q, phase_d;
  logic [EDGE_AW-1:0] edge_q, edge_d;
  logic [NODE_W-1:0]  iter_q, iter_d;
  logic               gos8_q, gos8_d;
  logic               done_q, done_d;
  logic               stop_q, stop_d;
  logic               neg_q, neg_d;
  logic               upd_q, upd_d;

  // Pass count + 1 kept one bit wider so saturation and the numNodes
  // comparison both see the true sum.
  logic [NODE_W:0]    iter_inc;
  logic [NODE_W-1:0]  iter_sat;
  logic               upd_any;
  logic               last_edge;

  // State register; reset overrides everything else.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= IDLE;
      edge_q  <= '0;
      iter_q  <= '0;
      gos8_q  <= 1'b0;
      done_q  <= 1'b0;
      stop_q  <= 1'b0;
      neg_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      edge_q  <= edge_d;
      iter_q  <= iter_d;
      gos8_q  <= gos8_d;
      done_q  <= done_d;
      stop_q  <= stop_d;
      neg_q   <= neg_d;
      upd_q   <= upd_d;
    end
  end

  // Next-state: clear on state 0/1, start a pass on 6, advance on relax pulses in 10.
  always_comb begin
    phase_d   = phase_q;
    edge_d    = edge_q;
    iter_d    = iter_q;
    gos8_d    = 1'b0;
    done_d    = done_q;
    stop_d    = stop_q;
    neg_d     = neg_q;
    upd_d     = upd_q;
    iter_inc  = {1'b0, iter_q} + {{NODE_W{1'b0}}, 1'b1};
    iter_sat  = iter_inc[NODE_W] ? iter_q : iter_inc[NODE_W-1:0];
    upd_any   = upd_q | bus.relaxUpdated;
    // ">=" rather than "==" keeps edgeAddr from ever running past the end.
    last_edge = (edge_q >= (bus.numEdges - EDGE_AW'(1)));

    if (bus.fsm_state == 5'd0 || bus.fsm_state == 5'd1) begin
      phase_d = IDLE;
      edge_d  = '0;
      iter_d  = '0;
      done_d  = 1'b0;
      stop_d  = 1'b0;
      neg_d   = 1'b0;
      upd_d   = 1'b0;
    end else if (bus.fsm_state == 5'd6 && phase_q != SCAN) begin
      phase_d = SCAN;
      edge_d  = '0;
      done_d  = 1'b0;
      stop_d  = 1'b0;
      neg_d   = 1'b0;
      upd_d   = 1'b0;
    end else if (phase_q == SCAN && bus.fsm_state == 5'd10) begin
      if (bus.numEdges == '0) begin
        // Empty graph: the pass is trivially complete and converged.
        phase_d = DONE;
        iter_d  = iter_sat;
        done_d  = 1'b1;
        stop_d  = 1'b1;
        neg_d   = 1'b0;
      end else if (bus.relaxValid) begin
        upd_d = upd_any;
        if (!last_edge) begin
          edge_d = edge_q + EDGE_AW'(1);
          gos8_d = 1'b1;
        end else begin
          phase_d = DONE;
          iter_d  = iter_sat;
          done_d  = 1'b1;
          stop_d  = !upd_any;
          neg_d   = upd_any && (iter_inc == {1'b0, bus.numNodes});
        end
      end
    end
  end

  assign bus.edgeAddr    = edge_q;
  assign bus.iterCount   = iter_q;
  assign bus.goS8        = gos8_q;
  assign bus.iterDone    = done_q;
  assign bus.iterStop    = stop_q;
  assign bus.negCycle    = neg_q;
  assign bus.updatedFlag = upd_q;
  assign bus.phase       = phase_q;

endmodule

// File: tb/tb_iter_ctrl.sv
// Directed bench for iter_ctrl: normal passes, convergence, negative cycle,
// empty graph, mid-scan reset and clear via state 1.
module tb_iter_ctrl;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  iter_ctrl_if #(.EDGE_AW(8), .NODE_W(8)) bus ();

  iter_ctrl #(.EDGE_AW(8), .NODE_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare and report
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
    chk("gos8_and_done_exclusive", {31'd0, bus.goS8 & bus.iterDone}, 32'd0);
    chk("stop_and_neg_exclusive", {31'd0, bus.iterStop & bus.negCycle}, 32'd0);
  endtask

  task automatic set_state(input logic [4:0] s);
    bus.fsm_state = s;
    tick();
  endtask

  task automatic pulse(input logic upd);
    bus.relaxValid   = 1'b1;
    bus.relaxUpdated = upd;
    tick();
    bus.relaxValid   = 1'b0;
    bus.relaxUpdated = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic done, input logic stop,
                           input logic neg, input int iter);
    chk({tag, "_iterDone"},  {31'd0, bus.iterDone}, {31'd0, done});
    chk({tag, "_iterStop"},  {31'd0, bus.iterStop}, {31'd0, stop});
    chk({tag, "_negCycle"},  {31'd0, bus.negCycle}, {31'd0, neg});
    chk({tag, "_iterCount"}, {24'd0, bus.iterCount}, iter);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_edgeAddr"},    {24'd0, bus.edgeAddr}, 32'd0);
    chk({tag, "_goS8"},        {31'd0, bus.goS8}, 32'd0);
    chk({tag, "_updatedFlag"}, {31'd0, bus.updatedFlag}, 32'd0);
    chk_flags(tag, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Directed scenarios
  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.fsm_state    = 5'd0;
    bus.numEdges     = 8'd3;
    bus.numNodes     = 8'd4;
    bus.relaxValid   = 1'b0;
    bus.relaxUpdated = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_all_zero("reset");

    // Pass 1: three edges, update on edge 1
    set_state(5'd6);
    chk("p1_start_edge", {24'd0, bus.edgeAddr}, 32'd0);
    bus.fsm_state = 5'd10;
    pulse(1'b0);
    chk("p1_e0_edge", {24'd0, bus.edgeAddr}, 32'd1);
    chk("p1_e0_gos8", {31'd0, bus.goS8}, 32'd1);
    tick();
    chk("p1_gos8_one_cycle", {31'd0, bus.goS8}, 32'd0);
    pulse(1'b1);
    chk("p1_e1_edge", {24'd0, bus.edgeAddr}, 32'd2);
    chk("p1_e1_gos8", {31'd0, bus.goS8}, 32'd1);
    chk("p1_e1_upd", {31'd0, bus.updatedFlag}, 32'd1);
    pulse(1'b0);
    chk("p1_e2_gos8", {31'd0, bus.goS8}, 32'd0);
    chk("p1_e2_edge", {24'd0, bus.edgeAddr}, 32'd2);
    chk_flags("p1_end", 1'b1, 1'b0, 1'b0, 1);
    // relaxValid in DONE changes nothing
    pulse(1'b1);
    chk_flags("p1_done_ignore", 1'b1, 1'b0, 1'b0, 1);
    chk("p1_done_edge", {24'd0, bus.edgeAddr}, 32'd2);

    // Pass 2: no updates -> converged
    set_state(5'd6);
    chk_flags("p2_start", 1'b0, 1'b0, 1'b0, 1);
    chk("p2_start_upd", {31'd0, bus.updatedFlag}, 32'd0);
    bus.fsm_state = 5'd10;
    pulse(1'b0);
    pulse(1'b0);
    pulse(1'b0);
    chk_flags("p2_end", 1'b1, 1'b1, 1'b0, 2);
    tick();
    chk_flags("p2_hold", 1'b1, 1'b1, 1'b0, 2);

    // State 1 clears everything
    set_state(5'd1);
    chk_all_zero("clear");

    // Negative cycle: numNodes=2, updates in both passes
    bus.numNodes = 8'd2;
    set_state(5'd6);
    bus.fsm_state = 5'd10;
    pulse(1'b1);
    pulse(1'b0);
    pulse(1'b0);
    chk_flags("neg_p1", 1'b1, 1'b0, 1'b0, 1);
    set_state(5'd6);
    bus.fsm_state = 5'd10;
    pulse(1'b0);
    pulse(1'b0);
    pulse(1'b1);
    chk_flags("neg_p2", 1'b1, 1'b0, 1'b1, 2);

    // Empty graph
    set_state(5'd1);
    bus.numEdges = 8'd0;
    set_state(5'd6);
    chk("empty_wait_done", {31'd0, bus.iterDone}, 32'd0);
    set_state(5'd10);
    chk_flags("empty", 1'b1, 1'b1, 1'b0, 1);
    chk("empty_gos8", {31'd0, bus.goS8}, 32'd0);

    // relaxValid outside state 10 ignored, then mid-scan reset
    set_state(5'd1);
    bus.numEdges = 8'd3;
    bus.numNodes = 8'd4;
    set_state(5'd6);
    bus.fsm_state = 5'd10;
    pulse(1'b0);
    tick();
    pulse(1'b1);
    chk("mid_edge2", {24'd0, bus.edgeAddr}, 32'd2);
    bus.fsm_state = 5'd8;
    pulse(1'b1);
    chk("not10_edge", {24'd0, bus.edgeAddr}, 32'd2);
    chk("not10_done", {31'd0, bus.iterDone}, 32'd0);
    bus.fsm_state    = 5'd10;
    reset            = 1'b1;
    bus.relaxValid   = 1'b1;
    bus.relaxUpdated = 1'b1;
    tick();
    reset            = 1'b0;
    bus.relaxValid   = 1'b0;
    bus.relaxUpdated = 1'b0;
    chk_all_zero("midreset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
